outer_in_packer32: RTL and testbench
====================================

# outer_in_packer32

Packs a 32-bit external input stream into the 64-bit outer-input words consumed on the `o__in` side of the outer-in adapter. Each command gives the frame length in 32-bit half-words. The block pairs consecutive half-words into 64-bit words, first half-word in the low bits. An odd-length frame gets its final word zero-padded in the high half, and that last word is flagged. It sits between the external 32-bit port and the outer-in adapter, and sustains one 32-bit half-word per cycle.

## Interface
- `MaxHalfLen`, default 15: width of the half-word count in the command.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-low; asserting it (low) at an edge clears all state.
- `cmd`  in  MaxHalfLen  frame length in 32-bit half-words; 0 means an empty frame.
- `cmd_isReady`  in  1  `cmd` is valid.
- `cmd_canReceive`  out  1  the block accepts a command this cycle.
- `x__in`  in  32  external half-word.
- `x__in_isReady`  in  1  `x__in` is valid.
- `x__in_canReceive`  out  1  the block accepts `x__in` this cycle.
- `o__in`  out  64  packed word.
- `o__in_isReady`  out  1  `o__in` is valid.
- `o__in_canReceive`  in  1  the downstream stage accepts `o__in`.
- `o__in_isLast`  out  1  `o__in` is the final word of the frame; valid only while `o__in_isReady` is high.

## Operation
- Handshake rule:
  - A transfer occurs on any channel when its isReady and canReceive are both high in the same cycle.
  - Producers must hold data stable until the transfer.
- State machine with states IDLE, LOW and HIGH.
- Registers:
  - `rem`: half-words remaining, MaxHalfLen bits.
  - `lo`: 32-bit low-half holding register.
  - Output register: `o__in`, `o__in_isReady`, `o__in_isLast`.
- Output register status:
  - The output register is *free* when `o__in_isReady` is 0, or when it is 1 and `o__in_canReceive` is 1 in the same cycle.
- IDLE:
  - `cmd_canReceive` = 1 and `x__in_canReceive` = 0.
  - On a command transfer with `cmd` ≠ 0: `rem` ← `cmd`, go to LOW.
  - On a command transfer with `cmd` = 0: consume the command, stay in IDLE, emit no output.
- LOW:
  - `cmd_canReceive` = 0.
  - If `rem` > 1:
    - `x__in_canReceive` = 1, regardless of the output register.
    - On transfer: `lo` ← `x__in`, `rem` ← `rem` − 1, go to HIGH.
  - If `rem` = 1:
    - `x__in_canReceive` = output register free.
    - On transfer: output ← {32'b0, `x__in`}, `isLast` ← 1, go to IDLE.
- HIGH:
  - `cmd_canReceive` = 0.
  - `x__in_canReceive` = output register free.
  - On transfer: output ← {`x__in`, `lo`} and `rem` ← `rem` − 1.
  - `isLast` ← 1 if `rem` was 1; go to IDLE if `rem` was 1, otherwise go to LOW.
- Output register update:
  - Loading and a downstream transfer in the same cycle is legal: the new word replaces the old one, and `o__in_isReady` stays 1.
  - A downstream transfer with no load clears `o__in_isReady` and `o__in_isLast`.
  - A word not yet accepted is never overwritten.
- A new command may be accepted while the previous frame's last word is still pending in the output register.
- `rem` arithmetic is unsigned MaxHalfLen bits. It never wraps, because a decrement occurs only while `rem` ≥ 1.
- Reset applied mid-frame:
  - State goes to IDLE and `rem` goes to 0.
  - The pending output is discarded and no partial word is emitted.
  - The next frame starts clean.

## Timing
- Reset values: `o__in_isReady` = 0, `o__in_isLast` = 0, `o__in` = 0, `x__in_canReceive` = 0.
- `cmd_canReceive` is 1 from the first cycle after reset is released.
- Latency:
  - The half-word completing a word (high half, or the odd last half) transfers in cycle t.
  - `o__in_isReady` = 1 with that word at t+1.
- Throughput: a continuous 1 half-word/cycle when downstream accepts every cycle, giving a packed word every 2 cycles.
- Frame-to-frame gap:
  - A command accepted in cycle t puts the block in LOW at t+1.
  - The first half-word can transfer at t+1.
  - The minimum gap is therefore 1 idle cycle (the command cycle) between frames.
- All canReceive outputs are combinational from registered state and the downstream `o__in_canReceive`. No canReceive depends on its own channel's isReady.

## Test plan
- Even frame:
  - Stimulus: `cmd` = 4, then `x__in` = 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back, downstream always ready.
  - Required: `o__in` = 0x2222222211111111 with `isLast` = 0, then 0x4444444433333333 with `isLast` = 1, each visible 1 cycle after its high half.
- Odd frame:
  - Stimulus: `cmd` = 3, then `x__in` = 0xA, 0xB, 0xC.
  - Required: 0x0000000B0000000A, then 0x000000000000000C with `isLast` = 1.
- Backpressure:
  - Stimulus: `cmd` = 4, `o__in_canReceive` held 0 for 5 cycles after the first word appears.
  - Required: the third half is accepted; the fourth is stalled (`x__in_canReceive` = 0) until downstream releases; no word is lost or duplicated.
- Empty frame:
  - Stimulus: `cmd` = 0, then `cmd` = 2 with 0x5, 0x6.
  - Required: no output for the first command; then exactly one word 0x0000000600000005 with `isLast` = 1.
- Overlapped commands:
  - Stimulus: the second command is presented while the last word of the first frame is held by `o__in_canReceive` = 0.
  - Required: `cmd_canReceive` = 1 and the command is accepted; the second frame's first half is accepted and its output waits for the first word to drain.
- Reset mid-frame:
  - Stimulus: drive `rst` = 0 after 1 half of a `cmd` = 4 frame.
  - Required: `o__in_isReady` = 0 and `cmd_canReceive` = 1 after release; the next `cmd` = 2 frame yields the correct single word.

Source files
------------

// File: rtl/outer_in_packer32_if.sv
// outer_in_packer32_if
// Groups the three handshake channels of the half-word packer.
//   cmd / cmd_isReady / cmd_canReceive           : frame length command
//   x__in / x__in_isReady / x__in_canReceive     : 32-bit half-word input
//   o__in / o__in_isReady / o__in_canReceive /
//   o__in_isLast                                 : 64-bit packed output
// A transfer happens on a channel in any cycle where its isReady and
// canReceive are both high; producers hold data stable until then.
// modport slave is the packer, modport master is its environment.
interface outer_in_packer32_if #(
    parameter int MaxHalfLen = 15
);
    logic [MaxHalfLen-1:0] cmd;
    logic                  cmd_isReady;
    logic                  cmd_canReceive;
    logic [31:0]           x__in;
    logic                  x__in_isReady;
    logic                  x__in_canReceive;
    logic [63:0]           o__in;
    logic                  o__in_isReady;
    logic                  o__in_canReceive;
    logic                  o__in_isLast;

    modport slave (
        input  cmd, cmd_isReady, x__in, x__in_isReady, o__in_canReceive,
        output cmd_canReceive, x__in_canReceive, o__in, o__in_isReady,
               o__in_isLast
    );

    modport master (
        output cmd, cmd_isReady, x__in, x__in_isReady, o__in_canReceive,
        input  cmd_canReceive, x__in_canReceive, o__in, o__in_isReady,
               o__in_isLast
    );
endinterface

// File: rtl/outer_in_packer32.sv
// outer_in_packer32
// Packs a stream of 32-bit half-words into 64-bit words, first half in the
// low bits. Each command carries the frame length in half-words; an odd
// frame ends with a word whose high half is zero. The final word of every
// frame is flagged with o__in_isLast. Sustains one half-word per cycle.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active low
//   bus          : outer_in_packer32_if.slave (cmd, x__in, o__in channels)
//   dbg_state_o  : current FSM state (IDLE=0, LOW=1, HIGH=2)
module outer_in_packer32 #(
    parameter int MaxHalfLen = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    outer_in_packer32_if.slave        bus,
    output logic [1:0]                dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [MaxHalfLen-1:0] ONE = MaxHalfLen'(1);

    state_t                state_q;
    logic [MaxHalfLen-1:0] rem_q;
    logic [31:0]           lo_q;
    logic [63:0]           out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;

    logic out_free;
    logic cmd_fire;
    logic x_fire;
    logic out_fire;

    // The output register can take a new word if it is empty or its
    // current word leaves this cycle.
    assign out_free = !out_valid_q || bus.o__in_canReceive;

    always_comb begin
        bus.cmd_canReceive   = 1'b0;
        bus.x__in_canReceive = 1'b0;
        case (state_q)
            IDLE: bus.cmd_canReceive = 1'b1;
            // A non-final low half only lands in lo_q, so the output
            // register does not gate it.
            LOW:  bus.x__in_canReceive = (rem_q > ONE) ? 1'b1 : out_free;
            HIGH: bus.x__in_canReceive = out_free;
            default: ;
        endcase
    end

    assign cmd_fire = bus.cmd_isReady && bus.cmd_canReceive;
    assign x_fire   = bus.x__in_isReady && bus.x__in_canReceive;
    assign out_fire = out_valid_q && bus.o__in_canReceive;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            lo_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            // Drain first; a load below in the same cycle overrides this.
            if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    // Zero-length commands are consumed without output.
                    if (cmd_fire && (bus.cmd != '0)) begin
                        rem_q   <= bus.cmd;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (x_fire) begin
                        rem_q <= rem_q - ONE;
                        if (rem_q > ONE) begin
                            lo_q    <= bus.x__in;
                            state_q <= HIGH;
                        end else begin
                            out_data_q  <= {32'h0, bus.x__in};
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                HIGH: begin
                    if (x_fire) begin
                        out_data_q  <= {bus.x__in, lo_q};
                        out_valid_q <= 1'b1;
                        out_last_q  <= (rem_q == ONE);
                        rem_q       <= rem_q - ONE;
                        state_q     <= (rem_q == ONE) ? IDLE : LOW;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o__in        = out_data_q;
    assign bus.o__in_isReady = out_valid_q;
    assign bus.o__in_isLast  = out_last_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_outer_in_packer32.sv
module tb_outer_in_packer32;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  outer_in_packer32_if #(.MaxHalfLen(15)) bus ();

  outer_in_packer32 #(.MaxHalfLen(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: {isLast, word}
  logic [64:0] exp_q[$];   // order in which words must leave downstream
  logic [64:0] load_q[$];  // words expected to appear one cycle after completion
  int          len_q[$];   // accepted non-empty frame lengths
  int          cur_len = 0;
  int          cur_cnt = 0;
  bit          pending_load = 0;

  logic [31:0] hw [16];
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: held off

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // downstream ready driver
  initial begin
    bus.o__in_canReceive = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.o__in_canReceive = 1'b1;
        1: bus.o__in_canReceive = 1'($urandom_range(0, 1));
        default: bus.o__in_canReceive = 1'b0;
      endcase
    end
  end

  // monitor: reference model works in terms of frames and half-word counts
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pending_load) begin
          pending_load = 0;
          chk("load_valid", {64'h0, bus.o__in_isReady}, 65'h1);
          if (load_q.size() == 0) chk("load_unexpected", 65'h1, 65'h0);
          else chk("load_word", {bus.o__in_isLast, bus.o__in}, load_q.pop_front());
        end
        if (bus.o__in_isReady && bus.o__in_canReceive) begin
          if (exp_q.size() == 0) chk("extra_word", {bus.o__in_isLast, bus.o__in}, 65'h0);
          else chk("drain_word", {bus.o__in_isLast, bus.o__in}, exp_q.pop_front());
        end
        if (bus.cmd_isReady && bus.cmd_canReceive && bus.cmd != 0)
          len_q.push_back(int'(bus.cmd));
        if (bus.x__in_isReady && bus.x__in_canReceive) begin
          if (cur_cnt == 0) begin
            if (len_q.size() == 0) begin
              chk("half_without_cmd", 65'h1, 65'h0);
              cur_len = 1;
            end else cur_len = len_q.pop_front();
          end
          cur_cnt++;
          if ((cur_cnt % 2 == 0) || (cur_cnt == cur_len)) pending_load = 1;
          if (cur_cnt == cur_len) cur_cnt = 0;
        end
      end
    end
  end

  // driver tasks: all start and end at posedge+#1
  task automatic do_cmd(input int n);
    bit ok = 0;
    bus.cmd = 15'(n);
    bus.cmd_isReady = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_canReceive) begin ok = 1; break; end
    end
    if (!ok) chk("cmd_timeout", 65'h1, 65'h0);
    @(posedge clk); #1;
    bus.cmd_isReady = 1'b0;
  endtask

  task automatic do_half(input logic [31:0] v, input bit gaps);
    bit ok = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.x__in = v;
    bus.x__in_isReady = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.x__in_canReceive) begin ok = 1; break; end
    end
    if (!ok) chk("half_timeout", 65'h1, 65'h0);
    @(posedge clk); #1;
    bus.x__in_isReady = 1'b0;
  endtask

  // Pushes the packed words implied by hw[0..n-1], then drives the frame.
  task automatic send_frame(input int n, input bit gaps);
    logic [64:0] w;
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) w = {1'b0, hw[i+1], hw[i]};
      else           w = {1'b0, 32'h0, hw[i]};
      w[64] = (i + 2 >= n);
      exp_q.push_back(w);
      load_q.push_back(w);
    end
    do_cmd(n);
    for (int i = 0; i < n; i++) do_half(hw[i], gaps);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    exp_q.delete(); load_q.delete(); len_q.delete();
    cur_cnt = 0; cur_len = 0; pending_load = 0;
    @(negedge clk);
    chk("rst_isReady", {64'h0, bus.o__in_isReady}, 65'h0);
    chk("rst_isLast", {64'h0, bus.o__in_isLast}, 65'h0);
    chk("rst_x_canReceive", {64'h0, bus.x__in_canReceive}, 65'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_canReceive", {64'h0, bus.cmd_canReceive}, 65'h1);
    chk("post_rst_isReady", {64'h0, bus.o__in_isReady}, 65'h0);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    chk("drain_left", 65'(exp_q.size()), 65'h0);
  endtask

  initial begin
    rst = 1'b0;
    bus.cmd = '0; bus.cmd_isReady = 1'b0;
    bus.x__in = '0; bus.x__in_isReady = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_o_data", {1'b0, bus.o__in}, 65'h0);
    @(posedge clk); #1;
    apply_reset();

    // even frame
    rdy_mode = 0;
    hw[0] = 32'h11111111; hw[1] = 32'h22222222; hw[2] = 32'h33333333; hw[3] = 32'h44444444;
    send_frame(4, 0);
    wait_drain();

    // odd frame
    hw[0] = 32'hA; hw[1] = 32'hB; hw[2] = 32'hC;
    send_frame(3, 0);
    wait_drain();

    // empty frame then two halves
    send_frame(0, 0);
    hw[0] = 32'h5; hw[1] = 32'h6;
    send_frame(2, 0);
    wait_drain();

    // backpressure: downstream off while the frame streams in
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) hw[i] = $urandom;
    fork
      send_frame(4, 0);
      begin
        repeat (6) @(negedge clk);
        chk("bp_x_stalled", {64'h0, bus.x__in_canReceive}, 65'h0);
        chk("bp_word_held", {bus.o__in_isLast, bus.o__in}, {1'b0, hw[1], hw[0]});
        rdy_mode = 0;
      end
    join
    wait_drain();

    // overlapped commands: last word of frame A held while B starts
    rdy_mode = 2;
    hw[0] = 32'hA0A0A0A0; hw[1] = 32'hA1A1A1A1;
    send_frame(2, 0);
    hw[0] = 32'hB0B0B0B0; hw[1] = 32'hB1B1B1B1;
    fork
      send_frame(2, 0);
      begin
        @(negedge clk);
        chk("ovl_cmd_canReceive", {64'h0, bus.cmd_canReceive}, 65'h1);
        repeat (4) @(negedge clk);
        chk("ovl_x_stalled", {64'h0, bus.x__in_canReceive}, 65'h0);
        chk("ovl_a_held", {bus.o__in_isLast, bus.o__in}, {1'b1, 32'hA1A1A1A1, 32'hA0A0A0A0});
        rdy_mode = 0;
      end
    join
    wait_drain();

    // reset mid-frame
    do_cmd(4);
    do_half(32'hDEADBEEF, 0);
    apply_reset();
    hw[0] = 32'h77; hw[1] = 32'h88;
    send_frame(2, 0);
    wait_drain();

    // randomized frames with random gaps and random downstream readiness
    rdy_mode = 1;
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(0, 9);
      for (int i = 0; i < n; i++) hw[i] = $urandom;
      send_frame(n, 1);
    end
    rdy_mode = 0;
    wait_drain();
    chk("load_left", 65'(load_q.size()), 65'h0);
    chk("frames_left", 65'(len_q.size() + cur_cnt), 65'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
